inst_sram_ctrl: RTL
===================

# inst_sram_ctrl

Instruction SRAM controller sitting between the program-load port and the IF stage of `mycpu_top`. It accepts program words on the load port (`inst_sram_wen`/`waddr`/`wdata`) while the core is held off, then switches to run mode on `inst_sram_en_toif` and serves IF fetches with a fixed one-cycle read latency. It is the receiving end of the load interface and the source side of the fetch interface.

## Interface
- `DEPTH_LOG2`, 10: log2 of array depth in 32-bit words.
- `ADDR_W`, 64: width of load address and fetch PC.
- `clk  in  1`: the only clock.
- `resetn  in  1`: asynchronous, active-low reset.
- `inst_sram_wen  in  1`: load write strobe, one word per cycle.
- `inst_sram_waddr  in  ADDR_W`: load word index, not a byte address.
- `inst_sram_wdata  in  32`: load data.
- `inst_sram_en_toif  in  1`: level; high = release array to IF.
- `if_req  in  1`: fetch request.
- `if_pc  in  ADDR_W`: fetch byte address.
- `if_addr_ok  out  1`: request accepted this cycle.
- `if_rvalid  out  1`: fetch data valid.
- `if_rdata  out  32`: fetched instruction.
- `if_aerr  out  1`: with `if_rvalid`, fetch was misaligned or out of range.
- `run_mode  out  1`: controller is in RUN.
- `load_cnt  out  DEPTH_LOG2+1`: number of accepted load writes, saturating.
- `load_err  out  1`: sticky; a load write was dropped.

## Operation
- States: LOAD (reset state) and RUN.
- LOAD → RUN when `inst_sram_en_toif`=1 is sampled. RUN → LOAD only on reset.
- In LOAD, a write is accepted when `wen`=1 and `waddr` < 2^DEPTH_LOG2. Accepting a write stores `wdata` at `waddr[DEPTH_LOG2-1:0]` and increments `load_cnt`, which saturates at 2^DEPTH_LOG2.
- In LOAD, a write with `waddr` ≥ 2^DEPTH_LOG2 is dropped and sets `load_err`.
- If `wen` and `en_toif` are high in the same cycle, the write is performed and the transition to RUN also happens.
- Writes in RUN are dropped and set `load_err`.
- In LOAD, `if_addr_ok`=0 and fetches are not accepted. IF stalls.
- In RUN, `if_addr_ok` = `if_req`. An accepted fetch reads word `if_pc[DEPTH_LOG2+1:2]`.
  - If `if_pc[1:0]`≠0 or `if_pc[ADDR_W-1:DEPTH_LOG2+2]`≠0, the fetch returns `if_rdata`=0 (nop) with `if_aerr`=1.
- Only written words have defined contents. The bench must load every address it fetches.
- Reset values: `run_mode`=0, `if_addr_ok`=0, `if_rvalid`=0, `if_rdata`=0, `if_aerr`=0, `load_cnt`=0, `load_err`=0.
- Reset does not clear the memory array.
- Reset mid-fetch drops the outstanding response.

## Timing
- Load write: data is visible to a fetch issued in any later cycle. No combinational write-to-read bypass is needed, because fetches are impossible in the write cycle.
- LOAD→RUN: `run_mode` and the first possible `if_addr_ok` appear the cycle after `en_toif` is sampled high.
- Fetch: request accepted at edge N; `if_rvalid`=1 with data at edge N+1.
- Back-to-back fetches give one response per cycle with no bubbles.
- `if_rvalid` is high for exactly one cycle per accepted request. There is no backpressure; IF must take the data.
- `if_rdata` holds its last value when `if_rvalid`=0.
- `load_err` and `load_cnt` update one cycle after the offending or accepted write.

## Configuration
- `INST_SRAM_PARITY_EN` defined:
  - Each word stores an extra even-parity bit, computed on load write.
  - The parity bit is checked on fetch read. A mismatch asserts output `if_perr` together with `if_rvalid`.
  - `if_perr` resets to 0.
- Macro undefined: no parity bit is stored, and the `if_perr` port does not exist.

## Structure
- Package `inst_sram_pkg` holds:
  - state enum `inst_sram_state_t` {LOAD, RUN};
  - the default `DEPTH_LOG2`;
  - the nop constant 32'h0;
  - the `if_aerr` decode helper function.
- Sub-module `inst_sram_mem`: single write port, single synchronous read port, width 32 or 33 depending on `INST_SRAM_PARITY_EN`.
- FSM, counters and fetch response logic live in `inst_sram_ctrl`.

## Test plan
- Load words 1..18 (addi x2,x0,6 = 32'h00600113 at 1; others at 2..18), then raise `en_toif`.
  - Expect `load_cnt`=18 and `run_mode`=1 one cycle later.
  - Fetch `if_pc`=0x4 → next cycle `if_rdata`=32'h00600113, `if_rvalid`=1.
- Streaming fetch of pc 0x4,0x8,…,0x48 on consecutive cycles → 18 consecutive `if_rvalid` pulses with data in load order and no gaps.
- `if_req`=1 during LOAD → `if_addr_ok`=0 and no `if_rvalid`.
- After RUN, fetch `if_pc`=0x6 → `if_rdata`=0, `if_aerr`=1.
- Load write to `waddr`=1024 (DEPTH_LOG2=10) → `load_err`=1 and `load_cnt` unchanged.
  - `wen` and `en_toif` in the same cycle → word stored, RUN entered, later fetch returns it.
- Reset asserted in the cycle after a fetch is accepted → `if_rvalid` stays 0 and state is LOAD.
  - After reload and RUN, fetch returns the retained array contents.
  - With `INST_SRAM_PARITY_EN`: force a parity flip on the array → `if_perr`=1 on that fetch.

Source files
------------

// File: rtl/inst_sram_pkg.sv
// Shared types, defaults and fetch-address decode for the instruction SRAM controller.
// No logic of its own; no latency, no backpressure.
// Parity support in the users is selected by INST_SRAM_PARITY_EN.
package inst_sram_pkg;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } inst_sram_state_t;

    localparam int          DEPTH_LOG2_DEF = 10;
    localparam logic [31:0] NOP_WORD       = 32'h0;

    // A fetch faults when the PC is not word aligned or points past the array.
    function automatic logic fetch_aerr(input logic [63:0] pc, input int dlog2);
        logic [63:0] hi;
        hi = pc >> (dlog2 + 2);
        return (pc[1:0] != 2'b00) || (hi != 64'd0);
    endfunction

endpackage

// File: rtl/inst_sram_mem.sv
// Single-write, single-read word array; read data registered and held between reads.
// Read latency one cycle; no backpressure, the array accepts one write and one read per cycle.
// Array contents are not reset; only the read-data register is.
module inst_sram_mem #(
    parameter int DEPTH_LOG2 = 10,
    parameter int WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem_q [2**DEPTH_LOG2];
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/inst_sram_ctrl.sv
// Instruction SRAM controller: program load port while held off, then IF fetch port (INST_SRAM_PARITY_EN adds if_perr).
// Fetch latency one cycle, one response per accepted request, back-to-back with no bubbles.
// No backpressure: IF must take every if_rvalid; fetches are refused (if_addr_ok=0) until RUN.
module inst_sram_ctrl
    import inst_sram_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int ADDR_W     = 64
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  inst_sram_wen,
    input  logic [ADDR_W-1:0]     inst_sram_waddr,
    input  logic [31:0]           inst_sram_wdata,
    input  logic                  inst_sram_en_toif,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_pc,
    output logic                  if_addr_ok,
    output logic                  if_rvalid,
    output logic [31:0]           if_rdata,
    output logic                  if_aerr,
`ifdef INST_SRAM_PARITY_EN
    output logic                  if_perr,
`endif
    output logic                  run_mode,
    output logic [DEPTH_LOG2:0]   load_cnt,
    output logic                  load_err
);

`ifdef INST_SRAM_PARITY_EN
    localparam int MEM_W = 33;
`else
    localparam int MEM_W = 32;
`endif
    localparam logic [DEPTH_LOG2:0] CNT_MAX = {1'b1, {DEPTH_LOG2{1'b0}}};

    inst_sram_state_t    state_q, state_d;
    logic [DEPTH_LOG2:0] load_cnt_q, load_cnt_d;
    logic                load_err_q, load_err_d;
    logic                rvalid_q, rvalid_d;
    logic                aerr_q, aerr_d;

    logic                wr_in_range;
    logic                wr_accept;
    logic                fetch_accept;
    logic [MEM_W-1:0]    mem_wdata;
    logic [MEM_W-1:0]    mem_rdata;

    assign wr_in_range = (inst_sram_waddr[ADDR_W-1:DEPTH_LOG2] == '0);

    always_comb begin
        state_d      = state_q;
        load_cnt_d   = load_cnt_q;
        load_err_d   = load_err_q;
        aerr_d       = aerr_q;
        wr_accept    = 1'b0;
        fetch_accept = 1'b0;
        if_addr_ok   = 1'b0;
        case (state_q)
            LOAD: begin
                if (inst_sram_wen) begin
                    if (wr_in_range) begin
                        wr_accept = 1'b1;
                        if (load_cnt_q != CNT_MAX) begin
                            load_cnt_d = load_cnt_q + (DEPTH_LOG2+1)'(1);
                        end
                    end else begin
                        load_err_d = 1'b1;
                    end
                end
                // A write in the same cycle as en_toif still lands before RUN.
                if (inst_sram_en_toif) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (inst_sram_wen) begin
                    load_err_d = 1'b1;
                end
                if_addr_ok   = if_req;
                fetch_accept = if_req;
            end
            default: state_d = LOAD;
        endcase
        rvalid_d = fetch_accept;
        if (fetch_accept) begin
            aerr_d = fetch_aerr(64'(if_pc), DEPTH_LOG2);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= LOAD;
            load_cnt_q <= '0;
            load_err_q <= 1'b0;
            rvalid_q   <= 1'b0;
            aerr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            load_err_q <= load_err_d;
            rvalid_q   <= rvalid_d;
            aerr_q     <= aerr_d;
        end
    end

`ifdef INST_SRAM_PARITY_EN
    assign mem_wdata = {^inst_sram_wdata, inst_sram_wdata};
`else
    assign mem_wdata = inst_sram_wdata;
`endif

    inst_sram_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (MEM_W)
    ) u_mem (
        .clk   (clk),
        .rst_n (resetn),
        .we    (wr_accept),
        .waddr (inst_sram_waddr[DEPTH_LOG2-1:0]),
        .wdata (mem_wdata),
        .re    (fetch_accept),
        .raddr (if_pc[DEPTH_LOG2+1:2]),
        .rdata (mem_rdata)
    );

    // aerr_q and the array read register only move on accepted fetches, so rdata holds.
    assign if_rdata  = aerr_q ? NOP_WORD : mem_rdata[31:0];
    assign if_rvalid = rvalid_q;
    assign if_aerr   = rvalid_q & aerr_q;
`ifdef INST_SRAM_PARITY_EN
    assign if_perr   = rvalid_q & ~aerr_q & ((^mem_rdata[31:0]) != mem_rdata[32]);
`endif
    assign run_mode  = (state_q == RUN);
    assign load_cnt  = load_cnt_q;
    assign load_err  = load_err_q;

endmodule
